// File: rtl/piso_frame_tx_fall.sv
// piso_frame_tx_fall: parallel-in, serial-out frame transmitter.
// Sends a start bit (0), then WIDTH data bits LSB first, then a stop bit (1).
// All state updates happen on the falling edge of clk. The reset is
// synchronous and active-low. Every output comes straight from a register.
module piso_frame_tx_fall #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             serial_out_bar,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             so_s;
  logic             busy_s;
  logic             done_s;

  // Next-state logic, plus the shift register and bit counter updates.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          shift_s = data_in;
          cnt_s   = '0;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Bit 0 is already in place, so this edge does not shift.
        state_s = ST_DATA;
      end
      ST_DATA: begin
        shift_s = {1'b0, shift_r[WIDTH-1:1]};
        cnt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Decode the line level and busy from the upcoming state so that both
  // outputs can be registered and still line up with the state.
  always_comb begin
    so_s   = 1'b1;
    busy_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        so_s   = 1'b1;
        busy_s = 1'b0;
      end
      ST_START: begin
        so_s   = 1'b0;
        busy_s = 1'b1;
      end
      ST_DATA: begin
        so_s   = shift_s[0];
        busy_s = 1'b1;
      end
      ST_STOP: begin
        so_s   = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        so_s   = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // Falling-edge state and output registers with synchronous active-low clear.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      shift_r        <= '0;
      cnt_r          <= '0;
      serial_out     <= 1'b1;
      serial_out_bar <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_r        <= state_s;
      shift_r        <= shift_s;
      cnt_r          <= cnt_s;
      serial_out     <= so_s;
      serial_out_bar <= ~so_s;
      busy           <= busy_s;
      done           <= done_s;
    end
  end

endmodule
